// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ADD   = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // 00 and 11 both leave A unchanged
  function automatic logic booth_is_nop(input logic [1:0] pair);
    return (pair == BOOTH_NOP) || (pair == 2'b11);
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/busy/done handshake and operand/product bus of the Booth multiplier.
interface booth_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, multiplicand, multiplier, input busy, done, product);
  modport slave  (input start, multiplicand, multiplier, output busy, done, product);
endinterface

// File: rtl/booth_datapath.sv
// A/Q/Q-1/M registers with add/sub and arithmetic shift, driven by FSM strobes.
// With BOOTH_SKIP_EN the bit pair seen after the next shift is exported for ADD bypass.
module booth_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                add,
  input  logic                sub,
  input  logic                shift,
  input  logic [WIDTH-1:0]    m_in,
  input  logic [WIDTH-1:0]    q_in,
  output logic [1:0]          pair,
`ifdef BOOTH_SKIP_EN
  output logic [1:0]          pair_after_shift,
`endif
  output logic [2*WIDTH-1:0]  prod_shifted
);

  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   m_ext;

  // A is one bit wider than M so A - (-2^(WIDTH-1)) stays representable
  assign m_ext        = {m_q[WIDTH-1], m_q};
  assign pair         = {q_q[0], qm1_q};
  assign prod_shifted = {a_q, q_q[WIDTH-1:1]};
`ifdef BOOTH_SKIP_EN
  assign pair_after_shift = q_q[1:0];
`endif

  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    qm1_d = qm1_q;
    m_d   = m_q;
    if (load) begin
      a_d   = '0;
      q_d   = q_in;
      qm1_d = 1'b0;
      m_d   = m_in;
    end else if (add) begin
      a_d = a_q + m_ext;
    end else if (sub) begin
      a_d = a_q - m_ext;
    end else if (shift) begin
      a_d   = {a_q[WIDTH], a_q[WIDTH:1]};
      q_d   = {a_q[0], q_q[WIDTH-1:1]};
      qm1_d = q_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
      m_q   <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      qm1_q <= qm1_d;
      m_q   <= m_d;
    end
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 signed Booth multiplier: control FSM and iteration counter.
// Define BOOTH_SKIP_EN to bypass ADD cycles for no-op bit pairs.
//   state | meaning
//   IDLE  | waiting for start
//   ADD   | conditional A +/- M from {Q[0],Q-1}
//   SHIFT | arithmetic right shift of {A,Q,Q-1}, count down
//   DONE  | product registered, done pulse; start here reloads
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_mult_seq_if.slave       bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 dp_load, dp_add, dp_sub, dp_shift;
  logic [1:0]           dp_pair;
  logic [2*WIDTH-1:0]   dp_prod_shifted;
  state_e               load_next, shift_next;

`ifdef BOOTH_SKIP_EN
  logic [1:0]           dp_pair_after;
  assign load_next  = bus.multiplier[0] ? ADD : SHIFT;
  assign shift_next = booth_is_nop(dp_pair_after) ? SHIFT : ADD;
`else
  assign load_next  = ADD;
  assign shift_next = ADD;
`endif

  booth_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk              (clk),
    .rst_n            (rst_n),
    .load             (dp_load),
    .add              (dp_add),
    .sub              (dp_sub),
    .shift            (dp_shift),
    .m_in             (bus.multiplicand),
    .q_in             (bus.multiplier),
    .pair             (dp_pair),
`ifdef BOOTH_SKIP_EN
    .pair_after_shift (dp_pair_after),
`endif
    .prod_shifted     (dp_prod_shifted)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    product_d = product_q;
    dp_load   = 1'b0;
    dp_add    = 1'b0;
    dp_sub    = 1'b0;
    dp_shift  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          dp_load = 1'b1;
          count_d = CW'(WIDTH);
          state_d = load_next;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        dp_add  = (dp_pair == BOOTH_ADD);
        dp_sub  = (dp_pair == BOOTH_SUB);
        state_d = SHIFT;
      end
      SHIFT: begin
        dp_shift = 1'b1;
        count_d  = count_q - CW'(1);
        if (count_d == '0) begin
          state_d   = DONE;
          product_d = dp_prod_shifted;
        end else begin
          state_d = shift_next;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ADD) || (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq (WIDTH=8 and WIDTH=16 instances); honours BOOTH_SKIP_EN.
module tb_booth_mult_seq;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  booth_mult_seq_if #(.WIDTH(8))  bus8  ();
  booth_mult_seq_if #(.WIDTH(16)) bus16 ();

  booth_mult_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  booth_mult_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch8(input logic [7:0] m, input logic [7:0] q);
    bus8.multiplicand = m;
    bus8.multiplier   = q;
    bus8.start        = 1'b1;
    tick();
    bus8.start = 1'b0;
  endtask

  // lat = edges after the accepted start edge until done is seen
  task automatic wait8(input string tag, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!bus8.done && lat < 40) begin
      bcnt += int'(bus8.busy);
      tick();
      lat++;
    end
    if (!bus8.done) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_lat8(input string tag, input int lat);
`ifdef BOOTH_SKIP_EN
    chk({tag, "_lat_max"}, 64'(lat + 1 <= 17), 64'd1);
`else
    chk({tag, "_lat"}, 64'(lat + 1), 64'd17);
`endif
  endtask

  task automatic run8(input string tag, input logic [7:0] m, input logic [7:0] q,
                      input logic [15:0] exp, output int lat);
    int bcnt;
    launch8(m, q);
    wait8(tag, lat, bcnt);
    chk({tag, "_prod"}, 64'(bus8.product), 64'(exp));
    check_lat8(tag, lat);
    tick();
    chk({tag, "_done_pulse"}, 64'(bus8.done), 64'd0);
  endtask

  initial begin
    int lat, bcnt, pulses;
    logic [15:0] seen;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0;  bus8.multiplicand = '0;  bus8.multiplier = '0;
    bus16.start = 1'b0; bus16.multiplicand = '0; bus16.multiplier = '0;
    #23;
    chk("rst_busy", 64'(bus8.busy), 64'd0);
    chk("rst_done", 64'(bus8.done), 64'd0);
    chk("rst_prod", 64'(bus8.product), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // 7 * 3 with full handshake timing
    launch8(8'h07, 8'h03);
    wait8("mul_7x3", lat, bcnt);
    chk("mul_7x3_prod", 64'(bus8.product), 64'h0015);
    check_lat8("mul_7x3", lat);
`ifndef BOOTH_SKIP_EN
    chk("mul_7x3_busy_cycles", 64'(bcnt), 64'd16);
`endif
    chk("mul_7x3_busy_at_done", 64'(bus8.busy), 64'd0);
    tick();
    chk("mul_7x3_done_pulse", 64'(bus8.done), 64'd0);

    run8("neg5x3",     8'hFB, 8'h03, 16'hFFF1, lat);
    run8("m128xm128",  8'h80, 8'h80, 16'h4000, lat);
    run8("m128x127",   8'h80, 8'h7F, 16'hC080, lat);
    run8("127x127",    8'h7F, 8'h7F, 16'h3F01, lat);
    run8("x55x55",     8'h55, 8'h55, 16'h1C39, lat);
    run8("zero",       8'h00, 8'h00, 16'h0000, lat);
`ifdef BOOTH_SKIP_EN
    chk("zero_skip_lat", 64'(lat + 1), 64'd9);
`endif

    // back-to-back: start held through DONE with new operands
    launch8(8'h07, 8'h03);
    wait8("b2b_first", lat, bcnt);
    chk("b2b_first_prod", 64'(bus8.product), 64'h0015);
    launch8(8'h0A, 8'hF6);
    chk("b2b_hold_prod", 64'(bus8.product), 64'h0015);
    chk("b2b_busy", 64'(bus8.busy), 64'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_hold_mid", 64'(bus8.product), 64'h0015);
    wait8("b2b_second", lat, bcnt);
    chk("b2b_second_prod", 64'(bus8.product), 64'hFF9C);
`ifndef BOOTH_SKIP_EN
    chk("b2b_second_lat", 64'(lat + 4 + 1), 64'd17);
`endif
    tick();

    // start pulse and operand changes while busy are ignored
    launch8(8'h7F, 8'h7F);
    tick(); tick();
    bus8.start = 1'b1; bus8.multiplicand = 8'h11; bus8.multiplier = 8'h22;
    tick(); tick();
    bus8.start = 1'b0; bus8.multiplicand = 8'hC3;
    pulses = 0;
    seen   = '0;
    for (int i = 0; i < 30; i++) begin
      if (bus8.done) begin
        pulses++;
        seen = bus8.product;
      end
      tick();
    end
    chk("busy_start_pulses", 64'(pulses), 64'd1);
    chk("busy_start_prod", 64'(seen), 64'h3F01);

    // async reset mid-operation
    launch8(8'h05, 8'h06);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus8.busy), 64'd0);
    chk("arst_done", 64'(bus8.done), 64'd0);
    chk("arst_prod", 64'(bus8.product), 64'd0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus8.done) pulses++;
      tick();
    end
    chk("arst_no_done", 64'(pulses), 64'd0);
    run8("arst_recover", 8'hFF, 8'hFF, 16'h0001, lat);

    // WIDTH=16 corner
    bus16.multiplicand = 16'h8000;
    bus16.multiplier   = 16'h0002;
    bus16.start        = 1'b1;
    tick();
    bus16.start = 1'b0;
    lat = 0;
    while (!bus16.done && lat < 80) begin
      tick();
      lat++;
    end
    chk("w16_done_seen", 64'(bus16.done), 64'd1);
    chk("w16_prod", 64'(bus16.product), 64'hFFFF0000);
`ifdef BOOTH_SKIP_EN
    chk("w16_lat_max", 64'(lat + 1 <= 33), 64'd1);
`else
    chk("w16_lat", 64'(lat + 1), 64'd33);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
